// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared types and widths for the KNN query sequencer
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REF,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DIMS       = 32;
  localparam int DEF_MAX_POINTS = 65535;
  localparam int DIM_CNT_W      = $clog2(DEF_DIMS);
  localparam int PT_CNT_W       = $clog2(DEF_MAX_POINTS + 1);

  function automatic logic points_legal(input logic [31:0] n, input int unsigned max_pts);
    return (n != 32'd0) && (n <= max_pts);
  endfunction

endpackage

// File: rtl/knn_sequencer.sv
// rtl/knn_sequencer.sv - control FSM sequencing one KNN query through the
// reference FIFO, distance accumulator and k-sorter
module knn_sequencer
  import knn_pkg::*;
#(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 32,
  parameter int maxPoints          = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [31:0]          num_points,
  input  logic                 abort,
  input  logic                 ref_in_valid,
  input  logic [dataWidth-1:0] ref_in_data,
  output logic                 ref_in_ready,
  input  logic                 pt_in_valid,
  input  logic [dataWidth-1:0] pt_in_data,
  input  logic [31:0]          pt_in_name,
  output logic                 pt_in_ready,
  output logic                 fifo_load,
  output logic [dataWidth-1:0] fifo_data,
  output logic                 dim_valid,
  output logic [dataWidth-1:0] dim_data,
  output logic [31:0]          name_out,
  input  logic                 dist_valid,
  output logic                 sort_done,
  output logic                 busy,
  output logic                 err
);

  localparam int DW = $clog2(numberOfDimensions);
  localparam int PW = $clog2(maxPoints + 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   dim_cnt;
  logic [PW-1:0]   pts_sent, pts_done, num_pts;
  logic            ref_beat, pt_beat, last_dim, last_pt, start_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ok     = points_legal(num_points, maxPoints);
    ref_beat     = (state == LOAD_REF) && ref_in_valid && !abort;
    pt_beat      = (state == STREAM) && pt_in_valid && !abort;
    last_dim     = (dim_cnt == DW'(numberOfDimensions - 1));
    last_pt      = (PW'(pts_sent + 1'b1) == num_pts);
    ref_in_ready = (state == LOAD_REF);
    pt_in_ready  = (state == STREAM);
    fifo_load    = ref_beat;
    fifo_data    = ref_beat ? ref_in_data : '0;
    busy         = (state != IDLE);
    sort_done    = (state == DONE) && !abort;
    case (state)
      IDLE:     if (start && start_ok) state_nxt = LOAD_REF;
      LOAD_REF: if (ref_beat && last_dim) state_nxt = STREAM;
      STREAM:   if (pt_beat && last_dim && last_pt) state_nxt = DRAIN;
      DRAIN:    if (pts_done == num_pts) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // abort outranks every other transition
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_cnt  <= '0;
      pts_sent <= '0;
      pts_done <= '0;
      num_pts  <= '0;
      err      <= 1'b0;
    end else if (state == IDLE) begin
      dim_cnt  <= '0;
      pts_sent <= '0;
      pts_done <= '0;
      if (start) begin
        if (start_ok) begin
          num_pts <= PW'(num_points);
          err     <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end else if (abort || state == DONE) begin
      dim_cnt  <= '0;
      pts_sent <= '0;
      pts_done <= '0;
    end else begin
      if (ref_beat || pt_beat) dim_cnt <= last_dim ? '0 : dim_cnt + 1'b1;
      if (pt_beat && last_dim) pts_sent <= pts_sent + 1'b1;
      if (dist_valid)          pts_done <= pts_done + 1'b1;
    end
  end

  // candidate register stage feeding the accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_valid <= 1'b0;
      dim_data  <= '0;
      name_out  <= '0;
    end else begin
      dim_valid <= pt_beat;
      if (pt_beat) dim_data <= pt_in_data;
      if (pt_beat && dim_cnt == '0) name_out <= pt_in_name;
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// tb/tb_knn_sequencer.sv - self-checking bench for knn_sequencer
module tb_knn_sequencer;

  localparam int DW_T  = 16;
  localparam int DIMS  = 4;
  localparam int MAXP  = 100;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, abort, ref_in_valid, pt_in_valid, dist_valid;
  logic [31:0]     num_points, pt_in_name;
  logic [DW_T-1:0] ref_in_data, pt_in_data;
  logic            ref_in_ready, pt_in_ready, fifo_load, dim_valid, sort_done, busy, err;
  logic [DW_T-1:0] fifo_data, dim_data;
  logic [31:0]     name_out;

  knn_sequencer #(.dataWidth(DW_T), .numberOfDimensions(DIMS), .maxPoints(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_points(num_points), .abort(abort),
    .ref_in_valid(ref_in_valid), .ref_in_data(ref_in_data), .ref_in_ready(ref_in_ready),
    .pt_in_valid(pt_in_valid), .pt_in_data(pt_in_data), .pt_in_name(pt_in_name),
    .pt_in_ready(pt_in_ready), .fifo_load(fifo_load), .fifo_data(fifo_data),
    .dim_valid(dim_valid), .dim_data(dim_data), .name_out(name_out),
    .dist_valid(dist_valid), .sort_done(sort_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW_T-1:0] data;
    logic [31:0]     name;
  } beat_t;

  typedef struct {
    logic [31:0] np;
    logic        exp_err;
    logic        exp_busy;
  } start_vec_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    fifo_cnt = 0;
  int    dv_cnt = 0;
  int    sd_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pulse counting and scoreboard comparison, half a cycle from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_load) begin
        fifo_cnt++;
        chk("fifo_data", 32'(fifo_data), 32'(ref_in_data));
      end
      if (dim_valid) begin
        dv_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dim_valid_unexpected: got dim_data %0h expected no beat", dim_data);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("dim_data", 32'(dim_data), 32'(e.data));
          chk("name_out", name_out, e.name);
        end
      end
      if (sort_done) sd_cnt++;
    end
  end

  task automatic do_start(input logic [31:0] np);
    start = 1'b1;
    num_points = np;
    step();
    start = 1'b0;
  endtask

  task automatic load_ref();
    int f0;
    f0 = fifo_cnt;
    for (int i = 0; i < DIMS; i++) begin
      ref_in_valid = 1'b1;
      ref_in_data = DW_T'($urandom);
      step();
    end
    ref_in_valid = 1'b0;
    chk("fifo_load_count", 32'(fifo_cnt - f0), DIMS);
    chk("pt_in_ready_after_ref", 32'(pt_in_ready), 1);
  endtask

  task automatic send_point(input logic [31:0] name, input bit gapped, input bit dist_on_last);
    for (int d = 0; d < DIMS; d++) begin
      if (gapped) begin
        pt_in_valid = 1'b0;
        step();
      end
      pt_in_valid = 1'b1;
      pt_in_data = DW_T'($urandom);
      pt_in_name = (d == 0) ? name : $urandom;
      dist_valid = dist_on_last && (d == DIMS - 1);
      if (pt_in_ready && !abort) sb.push_back('{pt_in_data, name});
      step();
    end
    pt_in_valid = 1'b0;
    dist_valid = 1'b0;
  endtask

  task automatic dist_pulse();
    dist_valid = 1'b1;
    step();
    dist_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 40 && sd_cnt < target; i++) step();
    chk({nm, "_sort_done"}, 32'(sd_cnt), 32'(target));
    repeat (3) step();
    chk({nm, "_sort_done_once"}, 32'(sd_cnt), 32'(target));
    chk({nm, "_busy_idle"}, 32'(busy), 0);
  endtask

  task automatic run_query(input bit gapped, input string nm);
    int d0, s0;
    d0 = dv_cnt;
    s0 = sd_cnt;
    do_start(2);
    load_ref();
    send_point(32'd7, gapped, 1'b0);
    send_point(32'd9, gapped, 1'b0);
    step();
    chk({nm, "_pt_ready_drain"}, 32'(pt_in_ready), 0);
    chk({nm, "_dim_valid_count"}, 32'(dv_cnt - d0), 2 * DIMS);
    chk({nm, "_no_early_done"}, 32'(sd_cnt), 32'(s0));
    dist_pulse();
    step();
    chk({nm, "_no_done_after_one"}, 32'(sd_cnt), 32'(s0));
    dist_pulse();
    wait_done(s0 + 1, nm);
  endtask

  start_vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd0,          1'b1, 1'b0};
    vecs[1] = '{32'd1,          1'b0, 1'b1};
    vecs[2] = '{32'd101,        1'b1, 1'b0};
    vecs[3] = '{32'd100,        1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[5] = '{32'd0,          1'b1, 1'b0};
    vecs[6] = '{32'd2,          1'b0, 1'b1};

    reset_n = 1'b0;
    start = 0; abort = 0; ref_in_valid = 0; pt_in_valid = 0; dist_valid = 0;
    num_points = 0; pt_in_name = 0; ref_in_data = 0; pt_in_data = 0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dim_valid", 32'(dim_valid), 0);
    chk("rst_ref_ready", 32'(ref_in_ready), 0);
    chk("rst_pt_ready", 32'(pt_in_ready), 0);
    chk("rst_sort_done", 32'(sort_done), 0);
    reset_n = 1'b1;
    step();

    // start legality table; legal starts are aborted back to IDLE
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].np);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_ref_ready", i), 32'(ref_in_ready), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk($sformatf("vec%0d_abort_idle", i), 32'(busy), 0);
      end
    end

    run_query(1'b0, "normal");
    run_query(1'b1, "gapped");

    begin : abort_stream
      int s0;
      s0 = sd_cnt;
      do_start(2);
      load_ref();
      for (int b = 0; b < 3; b++) begin
        pt_in_valid = 1'b1;
        pt_in_data = DW_T'($urandom);
        pt_in_name = 32'd5;
        abort = (b == 2);
        if (!abort) sb.push_back('{pt_in_data, 32'd5});
        step();
      end
      abort = 1'b0;
      pt_in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_dim_valid", 32'(dim_valid), 0);
      repeat (4) step();
      chk("abort_no_sort_done", 32'(sd_cnt), 32'(s0));
      do_start(1);
      load_ref();
      send_point(32'd3, 1'b0, 1'b0);
      dist_pulse();
      wait_done(s0 + 1, "after_abort");
    end

    begin : dist_same_cycle
      int s0;
      s0 = sd_cnt;
      do_start(1);
      load_ref();
      send_point(32'd11, 1'b0, 1'b1);
      wait_done(s0 + 1, "dist_on_last");
    end

    begin : reset_mid_stream
      do_start(2);
      load_ref();
      for (int b = 0; b < 2; b++) begin
        pt_in_valid = 1'b1;
        pt_in_data = DW_T'($urandom);
        pt_in_name = 32'd4;
        sb.push_back('{pt_in_data, 32'd4});
        step();
      end
      pt_in_valid = 1'b0;
      chk("pre_reset_dim_valid", 32'(dim_valid), 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_dim_valid", 32'(dim_valid), 0);
      chk("async_rst_fifo_load", 32'(fifo_load), 0);
      chk("async_rst_sort_done", 32'(sort_done), 0);
      sb.delete();
      step();
      reset_n = 1'b1;
      step();
      chk("post_reset_busy", 32'(busy), 0);
      chk("post_reset_ref_ready", 32'(ref_in_ready), 0);
    end

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_sequencer.md
Name: knn_sequencer

Overview:
- Control FSM that sequences one KNN query through the accelerator datapath: reference FIFO load, distance accumulator, k-sorter.
- Sits between the AXI-facing register/stream logic and the datapath.
- Loads the reference point, streams each candidate point dimension-by-dimension with a per-dimension valid strobe, and tracks distance results.
- Issues the sorter's done pulse once every candidate has been scored.

Parameters:
- dataWidth, 32, width of one dimension value.
- numberOfDimensions, 32, dimensions per point; must be ≥2.
- maxPoints, 65535, largest accepted num_points; sets the point-counter width (clog2(maxPoints+1)).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset; all state and outputs clear immediately.
- start  in  1  one-cycle query request; honoured only in IDLE.
- num_points  in  32  candidate count for the query; captured at start.
- abort  in  1  synchronous cancel; returns the FSM to IDLE next cycle.
- ref_in_valid  in  1  reference-word valid.
- ref_in_data  in  dataWidth  reference-word value.
- ref_in_ready  out  1  high only in LOAD_REF.
- pt_in_valid  in  1  candidate-word valid.
- pt_in_data  in  dataWidth  candidate-word value.
- pt_in_name  in  32  candidate label; sampled on the first dimension of each point.
- pt_in_ready  out  1  high only in STREAM.
- fifo_load  out  1  write strobe to the reference FIFO.
- fifo_data  out  dataWidth  reference word to the FIFO.
- dim_valid  out  1  one per accepted candidate dimension; drives accumulator dataIn_Valid.
- dim_data  out  dataWidth  registered candidate dimension.
- name_out  out  32  label of the point currently accumulating.
- dist_valid  in  1  accumulator result strobe.
- sort_done  out  1  one-cycle pulse to the sorter after the last result.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky; set when start carries num_points==0 or num_points>maxPoints; cleared by the next accepted start.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, LOAD_REF, STREAM, DRAIN, DONE.
- IDLE:
  - start with a legal num_points: capture num_points, clear err, go to LOAD_REF.
  - start with an illegal num_points: set err, stay in IDLE.
  - start while busy: ignored.
- LOAD_REF:
  - Each cycle with ref_in_valid: fifo_load=1 and fifo_data=ref_in_data, combinational pass-through in the same cycle.
  - Each such cycle increments dim_cnt.
  - On the numberOfDimensions-th word: dim_cnt resets to 0, go to STREAM.
- STREAM:
  - Each beat with pt_in_valid: registers dim_data=pt_in_data and asserts dim_valid on the next cycle (latency 1). The same beat increments dim_cnt.
  - On the beat with dim_cnt==0: name_out is registered from pt_in_name and is held until the next point's first beat.
  - On dim_cnt==numberOfDimensions-1: dim_cnt wraps to 0 and pts_sent increments.
  - When pts_sent reaches num_points: go to DRAIN. pt_in_ready drops in that same transition cycle.
  - Gaps in pt_in_valid are legal; dim_valid is simply low in those cycles.
- Result counting (any state except IDLE): pts_done increments on every dist_valid.
  - dist_valid arriving in IDLE is ignored.
  - dist_valid arriving in the same cycle as a STREAM→DRAIN transition is counted.
- DRAIN: wait until pts_done==num_points, then go to DONE.
- DONE:
  - sort_done=1 for exactly one cycle, then IDLE.
  - busy stays 1 during DONE and drops on entry to IDLE.
- abort (any non-IDLE state):
  - Next state is IDLE; counters clear; sort_done is not issued.
  - abort has priority over every other transition in the same cycle.
  - FIFO contents are left undefined; the next query reloads the reference.
- Widths:
  - dim_cnt is clog2(numberOfDimensions) bits.
  - pts_sent and pts_done are clog2(maxPoints+1) bits; comparisons use the captured num_points truncated to that width, which is legal after the range check.

Decomposition:
- Package knn_pkg:
  - state enum (IDLE..DONE);
  - localparam widths DIM_CNT_W and PT_CNT_W.
  - knnTop, the fifo and this block all use the package.
- No sub-module. A single FSM plus three counters fits in ~200 lines.

Test Plan:
- Reset during STREAM with reset_n=0 mid-point → busy, dim_valid, fifo_load and sort_done all drop to 0 asynchronously; state is IDLE after release.
- numberOfDimensions=4; start with num_points=2; 4 ref words → exactly 4 fifo_load pulses, then pt_in_ready rises. 8 pt words named 7 and 9 → 8 dim_valid pulses; name_out=7 then 9. Two dist_valid → one sort_done pulse, then busy=0.
- Gapped input: pt_in_valid toggling every other cycle → dim_valid count still 8; dim_data sequence matches the input order.
- start with num_points=0 → err=1, state stays IDLE, no ref_in_ready. A following start with num_points=1 → err clears.
- abort on the 3rd STREAM beat → IDLE next cycle, no sort_done. Then a fresh start with num_points=1 completes normally.
- dist_valid in the same cycle as the last pt beat (num_points=1, forced) → counted; sort_done still fires exactly once after DRAIN.
